// File: rtl/nanotrade_telem_pkg.sv
// rtl/nanotrade_telem_pkg.sv - shared types and frame byte helper for the telemetry event UART
package nanotrade_telem_pkg;
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 7;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;

  typedef struct packed {
    logic [3:0]  ch_idx;
    logic [3:0]  seq;
    logic [7:0]  code;
    logic [7:0]  health;
    logic [15:0] ts;
  } telem_entry_t;

  // Byte idx of a serial frame; the trailing byte is the XOR of the five payload bytes.
  function automatic logic [7:0] frame_byte(input telem_entry_t e, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = {e.ch_idx, e.seq};
      3'd2:    b = e.code;
      3'd3:    b = e.health;
      3'd4:    b = e.ts[15:8];
      3'd5:    b = e.ts[7:0];
      3'd6:    b = {e.ch_idx, e.seq} ^ e.code ^ e.health ^ e.ts[15:8] ^ e.ts[7:0];
      default: b = 8'hFF;
    endcase
    return b;
  endfunction
endpackage

// File: rtl/telem_sync_fifo.sv
// rtl/telem_sync_fifo.sv - show-ahead synchronous FIFO holding captured telemetry events
module telem_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A push at full is accepted only when a pop frees the slot in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end
endmodule

// File: rtl/telemetry_event_uart.sv
// rtl/telemetry_event_uart.sv - alert capture, arbitration, timestamping and 8N1 event framing
module telemetry_event_uart
  import nanotrade_telem_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int BURST_LEN  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           ch_alert,
  input  logic [8*NUM_CH-1:0]         ch_code,
  input  logic [7:0]                  health,
  input  logic                        enable,
  output logic                        uart_tx,
  output logic                        tx_busy,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  drop_cnt,
  output logic                        burst_active
);
  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int DIV_W    = $clog2(BAUD_DIV);

  logic [NUM_CH-1:0] r_prev, r_pending;
  logic [3:0]        r_seq;
  logic [15:0]       r_ts;
  logic [7:0]        r_drop, r_burst;
  tx_state_t         r_state, w_state_n;
  telem_entry_t      r_frame, w_entry, w_head;
  logic [2:0]        r_byte_idx, w_byte_n, r_bit_idx, w_bit_n;
  logic [DIV_W-1:0]  r_baud, w_baud_n;

  logic [NUM_CH-1:0] w_rise, w_clear;
  logic              w_grant_vld, w_push, w_pop, w_full, w_empty, w_bit_end;
  logic [3:0]        w_grant_idx;
  logic [7:0]        w_grant_code, w_cur_byte;
  logic [4:0]        w_drop_n;
  logic [8:0]        w_drop_sum;

  always_comb begin
    w_rise       = ch_alert & ~r_prev;
    w_grant_vld  = 1'b0;
    w_grant_idx  = '0;
    w_grant_code = '0;
    // Descending scan so the lowest-index pending channel wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_grant_vld  = 1'b1;
        w_grant_idx  = 4'(i);
        w_grant_code = ch_code[8*i +: 8];
      end
    end
    w_push   = w_grant_vld & ~w_full;
    w_clear  = '0;
    w_drop_n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_clear[i] = w_push && (w_grant_idx == 4'(i));
      w_drop_n   = w_drop_n + 5'(w_rise[i] & r_pending[i] & ~w_clear[i]);
    end
    w_drop_sum     = {1'b0, r_drop} + {4'b0, w_drop_n};
    w_entry.ch_idx = w_grant_idx;
    w_entry.seq    = r_seq;
    w_entry.code   = w_grant_code;
    w_entry.health = health;
    w_entry.ts     = r_ts;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= '1;
      r_pending <= '0;
      r_seq     <= '0;
      r_ts      <= '0;
      r_drop    <= '0;
      r_burst   <= '0;
    end else begin
      r_prev    <= ch_alert;
      r_pending <= (r_pending & ~w_clear) | w_rise;
      r_ts      <= r_ts + 16'd1;
      if (w_push) r_seq <= r_seq + 4'd1;
      r_drop    <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      r_burst   <= w_push ? 8'(BURST_LEN) : ((r_burst != 8'd0) ? r_burst - 8'd1 : 8'd0);
    end
  end

  telem_sync_fifo #(.WIDTH($bits(telem_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= TX_IDLE;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
      r_baud     <= '0;
      r_frame    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_byte_idx <= w_byte_n;
      r_bit_idx  <= w_bit_n;
      r_baud     <= w_baud_n;
      if (w_pop) r_frame <= w_head;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_pop      = 1'b0;
    w_byte_n   = r_byte_idx;
    w_bit_n    = r_bit_idx;
    w_baud_n   = r_baud + 1'b1;
    w_bit_end  = (r_baud == DIV_W'(BAUD_DIV - 1));
    w_cur_byte = frame_byte(r_frame, r_byte_idx);
    uart_tx    = 1'b1;
    tx_busy    = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      TX_IDLE, TX_DONE: begin
        frame_done = (r_state == TX_DONE);
        w_baud_n   = '0;
        w_state_n  = TX_IDLE;
        if (~w_empty && enable) begin
          w_pop     = 1'b1;
          w_byte_n  = '0;
          w_state_n = TX_START;
        end
      end
      TX_START: begin
        uart_tx = 1'b0;
        tx_busy = 1'b1;
        if (w_bit_end) begin
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        uart_tx = w_cur_byte[r_bit_idx];
        tx_busy = 1'b1;
        if (w_bit_end) begin
          w_baud_n = '0;
          if (r_bit_idx == 3'd7) w_state_n = TX_STOP;
          else                   w_bit_n   = r_bit_idx + 3'd1;
        end
      end
      TX_STOP: begin
        tx_busy = 1'b1;
        if (w_bit_end) begin
          w_baud_n = '0;
          if (r_byte_idx == 3'(FRAME_BYTES - 1)) begin
            w_state_n = TX_DONE;
          end else begin
            w_byte_n  = r_byte_idx + 3'd1;
            w_state_n = TX_START;
          end
        end
      end
      default: w_state_n = TX_IDLE;
    endcase
  end

  assign drop_cnt     = r_drop;
  assign burst_active = (r_burst != 8'd0);
endmodule
